// File: rtl/wb_memops.sv
// wb_memops: single-outstanding Wishbone pipelined master for CPU loads/stores.
//
// Accepts one byte/halfword/word load or store at a time, maps it onto
// big-endian byte lanes, runs one Wishbone cycle and reports completion
// (o_done), load data (o_valid/o_result/o_wreg) or an error (o_err).
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_stb, i_lock, i_op, i_addr,   CPU request: strobe, bus lock, op code
//   i_data, i_oreg                 ([2:1] size, [0] store), byte address,
//                                  store data, load destination tag
//   o_busy, o_rdbusy,              request / load outstanding, not accepting
//   o_pipe_stalled
//   o_valid, o_done, o_err,        completion status, load tag and data
//   o_wreg, o_result
//   o_wb_cyc/stb/we/addr/data/sel  Wishbone master outputs
//   i_wb_stall/ack/err/data        Wishbone slave responses
//
// Configuration: define WB_MEMOPS_LOCK_EN to let i_lock hold o_wb_cyc high
// across operations; otherwise i_lock is ignored.
module wb_memops #(
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stb,
  input  logic                     i_lock,
  input  logic [2:0]               i_op,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_data,
  input  logic [4:0]               i_oreg,
  output logic                     o_busy,
  output logic                     o_rdbusy,
  output logic                     o_pipe_stalled,
  output logic                     o_valid,
  output logic                     o_done,
  output logic                     o_err,
  output logic [4:0]               o_wreg,
  output logic [31:0]              o_result,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [31:0]              i_wb_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                   r_state, w_state_n;
  logic                     r_cyc, w_cyc_n, r_stb, w_stb_n, r_we, w_we_n;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_n;
  logic [31:0]              r_wdata, w_wdata_n, r_result, w_result_n;
  logic [3:0]               r_sel, w_sel_n;
  logic [4:0]               r_wreg, w_wreg_n;
  logic                     r_rd, w_rd_n;
  logic [1:0]               r_size, w_size_n, r_lo, w_lo_n;
  logic                     r_valid, w_valid_n, r_done, w_done_n, r_err, w_err_n;

  logic                     w_misaligned;
  logic [3:0]               w_sel_in;
  logic [31:0]              w_wdata_in, w_load_data;
  logic                     w_keep_cyc;

`ifdef WB_MEMOPS_LOCK_EN
  assign w_keep_cyc = i_lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = i_lock;
  assign w_keep_cyc    = 1'b0;
`endif

  // Lane mapping for the incoming request (byte 0 lives in bits 31:24).
  always_comb begin
    w_misaligned = 1'b0;
    w_sel_in     = 4'b1111;
    w_wdata_in   = i_data;
    case (i_op[2:1])
      2'b11: begin
        w_sel_in   = 4'b1000 >> i_addr[1:0];
        w_wdata_in = {4{i_data[7:0]}};
      end
      2'b10: begin
        w_misaligned = i_addr[0];
        w_sel_in     = i_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata_in   = {2{i_data[15:0]}};
      end
      default: w_misaligned = |i_addr[1:0];
    endcase
  end

  // Extract load data from the lane(s) latched at request time.
  always_comb begin
    w_load_data = i_wb_data;
    case (r_size)
      2'b11: begin
        case (r_lo)
          2'd0:    w_load_data = {24'h0, i_wb_data[31:24]};
          2'd1:    w_load_data = {24'h0, i_wb_data[23:16]};
          2'd2:    w_load_data = {24'h0, i_wb_data[15:8]};
          default: w_load_data = {24'h0, i_wb_data[7:0]};
        endcase
      end
      2'b10:   w_load_data = r_lo[1] ? {16'h0, i_wb_data[15:0]} : {16'h0, i_wb_data[31:16]};
      default: w_load_data = i_wb_data;
    endcase
  end

  always_comb begin
    w_state_n  = r_state;
    w_cyc_n    = r_cyc;
    w_stb_n    = r_stb;
    w_we_n     = r_we;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_sel_n    = r_sel;
    w_wreg_n   = r_wreg;
    w_rd_n     = r_rd;
    w_size_n   = r_size;
    w_lo_n     = r_lo;
    w_result_n = r_result;
    w_valid_n  = 1'b0;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A held (locked) cycle persists only while the lock is requested.
        w_cyc_n = r_cyc & w_keep_cyc;
        w_stb_n = 1'b0;
        if (i_stb) begin
          if (w_misaligned) begin
            w_err_n = 1'b1;
            w_cyc_n = 1'b0;
          end else begin
            w_state_n = StReq;
            w_cyc_n   = 1'b1;
            w_stb_n   = 1'b1;
            w_we_n    = i_op[0];
            w_addr_n  = i_addr[ADDRESS_WIDTH+1:2];
            w_wdata_n = w_wdata_in;
            w_sel_n   = w_sel_in;
            w_wreg_n  = i_oreg;
            w_rd_n    = ~i_op[0];
            w_size_n  = i_op[2:1];
            w_lo_n    = i_addr[1:0];
          end
        end
      end
      StReq, StWait: begin
        if (i_wb_err) begin
          w_state_n = StIdle;
          w_cyc_n   = 1'b0;
          w_stb_n   = 1'b0;
          w_err_n   = 1'b1;
        end else if (i_wb_ack && (r_state == StWait || !i_wb_stall)) begin
          w_state_n = StIdle;
          w_cyc_n   = w_keep_cyc;
          w_stb_n   = 1'b0;
          w_done_n  = 1'b1;
          w_valid_n = r_rd;
          if (r_rd) w_result_n = w_load_data;
        end else if (r_state == StReq && !i_wb_stall) begin
          w_state_n = StWait;
          w_stb_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = StIdle;
        w_cyc_n   = 1'b0;
        w_stb_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_wreg   <= '0;
      r_rd     <= 1'b0;
      r_size   <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cyc    <= w_cyc_n;
      r_stb    <= w_stb_n;
      r_we     <= w_we_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_sel    <= w_sel_n;
      r_wreg   <= w_wreg_n;
      r_rd     <= w_rd_n;
      r_size   <= w_size_n;
      r_lo     <= w_lo_n;
      r_result <= w_result_n;
      r_valid  <= w_valid_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  assign o_busy         = (r_state != StIdle);
  assign o_rdbusy       = o_busy & r_rd;
  assign o_pipe_stalled = o_busy;
  assign o_valid        = r_valid;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_wreg         = r_wreg;
  assign o_result       = r_result;
  assign o_wb_cyc       = r_cyc;
  assign o_wb_stb       = r_stb;
  assign o_wb_we        = r_we;
  assign o_wb_addr      = r_addr;
  assign o_wb_data      = r_wdata;
  assign o_wb_sel       = r_sel;

endmodule

// File: tb/tb_wb_memops.sv
// Self-checking bench for wb_memops: directed scenarios plus randomized
// operations against a byte-lane arithmetic reference model.
module tb_wb_memops;
  localparam int AW = 30;
`ifdef WB_MEMOPS_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset, i_stb, i_lock;
  logic [2:0]    i_op;
  logic [31:0]   i_addr, i_data;
  logic [4:0]    i_oreg;
  logic          o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_done, o_err;
  logic [4:0]    o_wreg;
  logic [31:0]   o_result;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0]   i_wb_data;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  wb_memops #(.ADDRESS_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_lock(i_lock), .i_op(i_op),
    .i_addr(i_addr), .i_data(i_data), .i_oreg(i_oreg), .o_busy(o_busy),
    .o_rdbusy(o_rdbusy), .o_pipe_stalled(o_pipe_stalled), .o_valid(o_valid),
    .o_done(o_done), .o_err(o_err), .o_wreg(o_wreg), .o_result(o_result),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b11) ? 1 : (size == 2'b10) ? 2 : 4;
  endfunction

  // One complete operation: request, optional stalls, optional wait cycles,
  // then ack (or err). Checks bus signals and completion against the model.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] tag, input int stalls, input int waits, input bit err,
                       input logic lock, input logic [31:0] rdata);
    int n, a, e;
    bit mis, ld, hold;
    logic [3:0]    esel;
    logic [31:0]   ewd, eres, mask;
    logic [AW-1:0] eaddr;
    n    = nbytes(op[2:1]);
    a    = int'(addr[1:0]);
    mis  = (a % n) != 0;
    ld   = !op[0];
    hold = LockEn && lock && !err;
    eaddr = addr[AW+1:2];
    i_stb = 1'b1; i_op = op; i_addr = addr; i_data = data; i_oreg = tag; i_lock = lock;
    tick();
    i_stb = 1'b0; i_op = 3'($urandom); i_addr = $urandom; i_data = $urandom;
    checks++;
    if (mis) begin
      if (o_wb_cyc !== 1'b0 || o_err !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL misalign cyc=%b err=%b done=%b busy=%b exp cyc=0 err=1 done=0 busy=0",
                 o_wb_cyc, o_err, o_done, o_busy);
      end
      tick();
      return;
    end
    e    = ((1 << n) - 1) << (4 - n - a);
    esel = e[3:0];
    ewd  = (n == 1) ? data[7:0] * 32'h0101_0101 : (n == 2) ? data[15:0] * 32'h0001_0001 : data;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    eres = (rdata >> (8 * (4 - n - a))) & mask;
    if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_wb_addr !== eaddr || o_wb_sel !== esel ||
        o_wb_we !== op[0] || (op[0] && o_wb_data !== ewd)) begin
      errors++;
      $display("FAIL request cyc=%b stb=%b addr=%h sel=%b we=%b data=%h exp 1 1 %h %b %b %h",
               o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_sel, o_wb_we, o_wb_data, eaddr, esel, op[0], ewd);
    end
    checks++;
    if (o_busy !== 1'b1 || o_pipe_stalled !== 1'b1 || o_rdbusy !== ld) begin
      errors++;
      $display("FAIL busy busy=%b stalled=%b rdbusy=%b exp 1 1 %b", o_busy, o_pipe_stalled,
               o_rdbusy, ld);
    end
    i_wb_stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      tick();
      checks++;
      if (o_wb_stb !== 1'b1 || o_wb_cyc !== 1'b1 || o_wb_addr !== eaddr || o_wb_sel !== esel) begin
        errors++;
        $display("FAIL stall_hold stb=%b cyc=%b addr=%h sel=%b exp 1 1 %h %b", o_wb_stb, o_wb_cyc,
                 o_wb_addr, o_wb_sel, eaddr, esel);
      end
    end
    i_wb_stall = 1'b0;
    if (waits > 0) begin
      tick();
      checks++;
      if (o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_state stb=%b cyc=%b busy=%b exp 0 1 1", o_wb_stb, o_wb_cyc, o_busy);
      end
      for (int i = 1; i < waits; i++) tick();
    end
    i_wb_ack  = !err || ($urandom_range(0, 1) == 1);
    i_wb_err  = err;
    i_wb_data = rdata;
    tick();
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = $urandom;
    checks++;
    if (o_done !== !err || o_valid !== (ld && !err) || o_err !== err || o_busy !== 1'b0 ||
        o_wb_stb !== 1'b0 || o_wb_cyc !== hold) begin
      errors++;
      $display("FAIL complete done=%b valid=%b err=%b busy=%b stb=%b cyc=%b exp %b %b %b 0 0 %b",
               o_done, o_valid, o_err, o_busy, o_wb_stb, o_wb_cyc, !err, ld && !err, err, hold);
    end
    checks++;
    if (o_wreg !== tag || (ld && !err && o_result !== eres)) begin
      errors++;
      $display("FAIL load_data result=%h wreg=%0d exp %h %0d", o_result, o_wreg, eres, tag);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_valid !== 1'b0 || o_err !== 1'b0 || o_wb_cyc !== hold) begin
      errors++;
      $display("FAIL one_cycle done=%b valid=%b err=%b cyc=%b exp 0 0 0 %b", o_done, o_valid,
               o_err, o_wb_cyc, hold);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_stb = 1'b0; i_lock = 1'b0; i_op = 3'b010; i_addr = '0; i_data = '0;
    i_oreg = '0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
    tick();
    tick();
    checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_rdbusy, o_valid, o_done, o_err} !== 8'h00 ||
        o_result !== 32'h0 || o_wreg !== 5'h0 || o_wb_addr !== '0 || o_wb_data !== 32'h0 ||
        o_wb_sel !== 4'h0) begin
      errors++;
      $display("FAIL reset cyc=%b stb=%b busy=%b done=%b err=%b res=%h sel=%b exp all zero",
               o_wb_cyc, o_wb_stb, o_busy, o_done, o_err, o_result, o_wb_sel);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_directed();
    do_op(3'b010, 32'h0000_1004, 32'h0, 5'd7, 0, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
    do_op(3'b111, 32'h0000_0003, 32'h0000_00A5, 5'd2, 0, 1, 1'b0, 1'b0, 32'h0);
    do_op(3'b100, 32'h0000_0002, 32'h0, 5'd9, 3, 1, 1'b0, 1'b0, 32'h1234_ABCD);
    do_op(3'b010, 32'h0000_0006, 32'h0, 5'd4, 0, 0, 1'b0, 1'b0, 32'h0);
    do_op(3'b010, 32'h0000_0100, 32'h0, 5'd5, 0, 1, 1'b1, 1'b0, 32'h5555_AAAA);
    do_op(3'b110, 32'h0000_0000, 32'h0, 5'd1, 1, 0, 1'b0, 1'b0, 32'h8899_AABB);
  endtask

  task automatic test_reset_mid();
    i_stb = 1'b1; i_op = 3'b010; i_addr = 32'h10; i_oreg = 5'd3;
    tick();
    i_stb = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'hCAFE_F00D;
    checks++;
    if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0 || o_wb_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid cyc=%b busy=%b stb=%b exp 0 0 0", o_wb_cyc, o_busy, o_wb_stb);
    end
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (o_done !== 1'b0 || o_valid !== 1'b0 || o_err !== 1'b0 || o_wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL late_ack done=%b valid=%b err=%b cyc=%b exp 0 0 0 0", o_done, o_valid,
               o_err, o_wb_cyc);
    end
  endtask

  task automatic test_stb_while_busy();
    i_stb = 1'b1; i_op = 3'b010; i_addr = 32'h20; i_oreg = 5'd3;
    tick();
    i_op = 3'b011; i_addr = 32'h40; i_oreg = 5'd12; i_wb_stall = 1'b1;
    tick();
    i_wb_stall = 1'b0;
    tick();
    checks++;
    if (o_wb_addr !== 30'h8 || o_wb_we !== 1'b0 || o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL stb_busy addr=%h we=%b stb=%b cyc=%b exp 8 0 0 1", o_wb_addr, o_wb_we,
               o_wb_stb, o_wb_cyc);
    end
    i_stb = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h1122_3344;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b1 || o_result !== 32'h1122_3344 || o_wreg !== 5'd3) begin
      errors++;
      $display("FAIL stb_busy_done done=%b valid=%b res=%h wreg=%0d exp 1 1 11223344 3", o_done,
               o_valid, o_result, o_wreg);
    end
    tick();
  endtask

  task automatic test_lock();
    do_op(3'b010, 32'h0000_0200, 32'h0, 5'd10, 0, 1, 1'b0, 1'b1, 32'h0102_0304);
    do_op(3'b010, 32'h0000_0204, 32'h0, 5'd11, 0, 0, 1'b0, 1'b1, 32'h0506_0708);
    i_lock = 1'b0;
    tick();
    checks++;
    if (o_wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL lock_release cyc=%b exp 0", o_wb_cyc);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      int n;
      op   = {2'($urandom_range(1, 3)), 1'($urandom)};
      n    = nbytes(op[2:1]);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(n) - 32'h1);
      do_op(op, addr, $urandom, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 7) == 0, 1'b0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_stb_while_busy();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
